// File: rtl/ofdm_pkg.sv
// Shared defaults and state encoding for the OFDM frame scheduler.
package ofdm_pkg;

  localparam int OFDM_NSC     = 8;   // subcarriers (samples) per symbol
  localparam int OFDM_W       = 32;  // sample width {imag[15:0], real[15:0]}
  localparam int OFDM_N_PRE   = 2;   // preamble symbols per frame
  localparam int OFDM_N_DATA  = 4;   // data symbols per frame
  localparam int OFDM_GAP_CYC = 16;  // idle cycles after each frame

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/ofdm_frame_scheduler.sv
// OFDM frame scheduler: multiplexes preamble and QAM-mapper sample streams
// into the IFFT input as frames of N_PRE preamble symbols followed by
// N_DATA data symbols, then holds the output idle for GAP_CYC cycles.
// Symbol boundaries come only from the internal sample counter.
module ofdm_frame_scheduler
  import ofdm_pkg::*;
#(
  parameter int NSC     = OFDM_NSC,
  parameter int W       = OFDM_W,
  parameter int N_PRE   = OFDM_N_PRE,
  parameter int N_DATA  = OFDM_N_DATA,
  parameter int GAP_CYC = OFDM_GAP_CYC
) (
  input  logic         aclk,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] pre_tdata,
  input  logic         pre_tvalid,
  output logic         pre_tready,
  input  logic [W-1:0] map_tdata,
  input  logic         map_tvalid,
  output logic         map_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tvalid,
  output logic         m_tlast,
  input  logic         m_tready,
  output logic         frame_start,
  output logic [3:0]   sym_idx,
  output logic         busy
);

  localparam int SMP_W = (NSC > 1) ? $clog2(NSC) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [SMP_W-1:0] SMP_LAST     = SMP_W'(NSC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       PRE_SYM_LAST = 4'(N_PRE - 1);
  localparam logic [3:0]       SYM_LAST     = 4'(N_PRE + N_DATA - 1);

  state_t             state_q, state_d;
  logic [SMP_W-1:0]   smp_q,   smp_d;
  logic [3:0]         sym_q,   sym_d;
  logic [GAP_W-1:0]   gap_q,   gap_d;
  logic               xfer;

  // State and counter registers; reset returns to IDLE with all counters cleared.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      smp_q   <= '0;
      sym_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      sym_q   <= sym_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic, output mux and counter advance, all in one process.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    sym_d       = sym_q;
    gap_d       = gap_q;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    pre_tready  = 1'b0;
    map_tready  = 1'b0;
    frame_start = 1'b0;
    sym_idx     = sym_q;
    busy        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PRE;
      end
      ST_PRE: begin
        m_tdata    = pre_tdata;
        m_tvalid   = pre_tvalid;
        pre_tready = m_tready;
      end
      ST_DATA: begin
        m_tdata    = map_tdata;
        m_tvalid   = map_tvalid;
        map_tready = m_tready;
      end
      ST_GAP: begin
        // Gap length is fixed; enable is only consulted when it expires.
        if (gap_q == GAP_LAST) begin
          state_d = enable ? ST_PRE : ST_IDLE;
          gap_d   = '0;
          sym_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // m_tvalid is forced low in IDLE/GAP, so these only act in PRE/DATA.
    xfer    = m_tvalid && m_tready;
    m_tlast = m_tvalid && (smp_q == SMP_LAST);

    if (xfer) begin
      frame_start = (state_q == ST_PRE) && (sym_q == '0) && (smp_q == '0);
      if (smp_q == SMP_LAST) begin
        smp_d = '0;
        if (state_q == ST_PRE && sym_q == PRE_SYM_LAST) begin
          state_d = ST_DATA;
          sym_d   = sym_q + 4'd1;
        end else if (state_q == ST_DATA && sym_q == SYM_LAST) begin
          // Final symbol: hold sym_idx at its last value through the gap.
          state_d = ST_GAP;
          gap_d   = '0;
        end else begin
          sym_d = sym_q + 4'd1;
        end
      end else begin
        smp_d = smp_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ofdm_frame_scheduler.sv
// Testbench for ofdm_frame_scheduler with a transfer-count reference model.
module tb_ofdm_frame_scheduler;
  import ofdm_pkg::*;

  localparam int NSC   = OFDM_NSC;
  localparam int W     = OFDM_W;
  localparam int NPRE  = OFDM_N_PRE;
  localparam int NDATA = OFDM_N_DATA;
  localparam int GAP   = OFDM_GAP_CYC;
  localparam int TOT   = (NPRE + NDATA) * NSC;
  localparam int OW    = W + 10;

  logic         aclk = 1'b0;
  logic         reset, enable;
  logic [W-1:0] pre_tdata, map_tdata;
  logic         pre_tvalid, map_tvalid, m_tready;
  logic         pre_tready, map_tready, m_tvalid, m_tlast, frame_start, busy;
  logic [W-1:0] m_tdata;
  logic [3:0]   sym_idx;
  logic [OW-1:0] obs;

  always #5 aclk = ~aclk;

  ofdm_frame_scheduler #(
    .NSC(NSC), .W(W), .N_PRE(NPRE), .N_DATA(NDATA), .GAP_CYC(GAP)
  ) dut (
    .aclk(aclk), .reset(reset), .enable(enable),
    .pre_tdata(pre_tdata), .pre_tvalid(pre_tvalid), .pre_tready(pre_tready),
    .map_tdata(map_tdata), .map_tvalid(map_tvalid), .map_tready(map_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_start(frame_start), .sym_idx(sym_idx), .busy(busy)
  );

  assign obs = {m_tvalid, m_tlast, pre_tready, map_tready, frame_start, busy, sym_idx, m_tdata};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: mode (0 idle, 1 in frame, 2 gap), transfers so far in
  // the frame, gap cycles elapsed.
  int md, mk, mg;
  int unsigned p_pre, p_map, p_rdy;
  bit en, tog, rel_pending;
  int stall_left;
  logic [OW-1:0] exp_v;

  function automatic logic [OW-1:0] model_out();
    logic v, lst, pr, mr, fs, bz;
    logic [3:0] s;
    logic [W-1:0] d;
    bit from_pre;
    v = 0; lst = 0; pr = 0; mr = 0; fs = 0; bz = 0; s = '0; d = '0;
    if (md == 1) begin
      from_pre = (mk < NPRE * NSC);
      v   = from_pre ? pre_tvalid : map_tvalid;
      d   = from_pre ? pre_tdata : map_tdata;
      pr  = from_pre && m_tready;
      mr  = !from_pre && m_tready;
      lst = v && ((mk % NSC) == NSC - 1);
      s   = 4'(mk / NSC);
      fs  = v && m_tready && (mk == 0);
      bz  = 1;
    end else if (md == 2) begin
      bz = 1;
      s  = 4'(NPRE + NDATA - 1);
    end
    return {v, lst, pr, mr, fs, bz, s, d};
  endfunction

  task automatic model_reset();
    md = 0; mk = 0; mg = 0;
  endtask

  task automatic drive();
    @(negedge aclk);
    if (rel_pending) begin
      reset = 1'b0;
      rel_pending = 0;
    end
    enable     = en;
    pre_tvalid = ($urandom_range(0, 99) < p_pre);
    map_tvalid = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < p_map);
    if (stall_left > 0) stall_left--;
    m_tready   = tog ? ~m_tready : ($urandom_range(0, 99) < p_rdy);
    pre_tdata  = $urandom;
    map_tdata  = $urandom;
    #1;
    exp_v = model_out();
  endtask

  task automatic advance();
    bit x;
    x = (md == 1) && exp_v[OW-1] && m_tready;
    @(posedge aclk);
    cyc++;
    case (md)
      0: if (enable) begin md = 1; mk = 0; end
      1: if (x) begin
           mk++;
           if (mk == TOT) begin md = 2; mg = 0; end
         end
      default: begin
        mg++;
        if (mg == GAP) begin md = enable ? 1 : 0; mk = 0; end
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 0; enable = 1'b0; tog = 0; stall_left = 0; rel_pending = 0;
    pre_tvalid = 1'b0; map_tvalid = 1'b0; m_tready = 1'b0;
    pre_tdata = '0; map_tdata = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; pre_tvalid = 1'b1; map_tvalid = 1'b1; m_tready = 1'b1;
    pre_tdata = 32'h1234_5678; map_tdata = 32'h9abc_def0;
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_immediate: got %h expected %h", obs, {OW{1'b0}});
    end
    repeat (2) @(posedge aclk);
    #1;
    tests++;
    if (obs !== '0) begin
      fails++;
      $display("FAIL reset_held: got %h expected %h", obs, {OW{1'b0}});
    end
  endtask

  task automatic test_nominal();
    int fs1, fs2, tl;
    do_reset();
    p_pre = 100; p_map = 100; p_rdy = 100; en = 1;
    fs1 = -1; fs2 = -1; tl = 0;
    for (int i = 0; i < 150; i++) begin
      drive();
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL nominal cyc %0d: got %h expected %h", cyc, obs, exp_v);
      end
      if (frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i;
      end
      if (i < 65 && m_tlast === 1'b1) tl++;
      advance();
    end
    tests++;
    if (fs1 != 1 || fs2 != 1 + TOT + GAP) begin
      fails++;
      $display("FAIL nominal_frame_start: got %0d,%0d expected 1,%0d", fs1, fs2, 1 + TOT + GAP);
    end
    tests++;
    if (tl != NPRE + NDATA) begin
      fails++;
      $display("FAIL nominal_tlast_count: got %0d expected %0d", tl, NPRE + NDATA);
    end
  endtask

  task automatic test_ready_toggle();
    int fs1, fs2, nx;
    do_reset();
    p_pre = 100; p_map = 100; en = 1; tog = 1;
    fs1 = -1; fs2 = -1; nx = 0;
    for (int i = 0; i < 260; i++) begin
      drive();
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL ready_toggle cyc %0d: got %h expected %h", cyc, obs, exp_v);
      end
      if (frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = i; else if (fs2 < 0) fs2 = i;
      end
      if (fs1 >= 0 && fs2 < 0 && m_tvalid === 1'b1 && m_tready === 1'b1) nx++;
      advance();
    end
    tests++;
    if (fs1 < 0 || fs2 - fs1 != 2 * TOT + GAP) begin
      fails++;
      $display("FAIL ready_toggle_spacing: got %0d expected %0d", fs2 - fs1, 2 * TOT + GAP);
    end
    tests++;
    if (nx != TOT) begin
      fails++;
      $display("FAIL ready_toggle_transfers: got %0d expected %0d", nx, TOT);
    end
    tog = 0;
  endtask

  task automatic test_map_stall();
    bit stalled;
    do_reset();
    p_pre = 100; p_map = 100; p_rdy = 100; en = 1; stalled = 0;
    for (int i = 0; i < 120; i++) begin
      if (md == 1 && mk == NPRE * NSC + 3 && !stalled) begin
        stall_left = 5;
        stalled = 1;
      end
      drive();
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL map_stall cyc %0d: got %h expected %h", cyc, obs, exp_v);
      end
      advance();
    end
  endtask

  task automatic test_enable_drop();
    int max_sym, n;
    bit done;
    do_reset();
    p_pre = 100; p_map = 100; p_rdy = 80; en = 1; max_sym = 0; done = 0; n = 0;
    while (n < 600 && !done) begin
      if (md == 1 && mk >= NPRE * NSC + NSC && mk < NPRE * NSC + 2 * NSC) en = 0;
      drive();
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL enable_drop cyc %0d: got %h expected %h", cyc, obs, exp_v);
      end
      if (busy === 1'b1 && int'(sym_idx) > max_sym) max_sym = int'(sym_idx);
      advance();
      n++;
      if (md == 0 && en == 0) done = 1;
    end
    drive();
    tests++;
    if (!done || busy !== 1'b0) begin
      fails++;
      $display("FAIL enable_drop_idle: got busy=%b done=%0d expected busy=0 done=1", busy, done);
    end
    tests++;
    if (max_sym != NPRE + NDATA - 1) begin
      fails++;
      $display("FAIL enable_drop_max_sym: got %0d expected %0d", max_sym, NPRE + NDATA - 1);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    bit hit, got_fs;
    logic [3:0] fs_sym;
    do_reset();
    p_pre = 100; p_map = 100; p_rdy = 100; en = 1; hit = 0; got_fs = 0; fs_sym = 4'hf;
    for (int i = 0; i < 120; i++) begin
      drive();
      tests++;
      if (obs !== exp_v) begin
        fails++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", cyc, obs, exp_v);
      end
      if (hit && !got_fs && frame_start === 1'b1) begin
        got_fs = 1;
        fs_sym = sym_idx;
      end
      if (md == 1 && mk == 5 && !hit) begin
        hit = 1;
        reset = 1'b1;
        #1;
        tests++;
        if (obs !== '0) begin
          fails++;
          $display("FAIL reset_mid_outputs: got %h expected %h", obs, {OW{1'b0}});
        end
        model_reset();
        rel_pending = 1;
        continue;
      end
      advance();
    end
    tests++;
    if (!got_fs || fs_sym !== 4'd0) begin
      fails++;
      $display("FAIL reset_mid_restart: got fs=%0d sym=%h expected fs=1 sym=0", got_fs, fs_sym);
    end
  endtask

  task automatic test_random();
    do_reset();
    en = 1;
    for (int blk = 0; blk < 15; blk++) begin
      p_pre = $urandom_range(40, 100);
      p_map = $urandom_range(40, 100);
      p_rdy = $urandom_range(40, 100);
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 3) en = ~en;
        if (stall_left == 0 && $urandom_range(0, 99) < 2) stall_left = $urandom_range(1, 6);
        drive();
        tests++;
        if (obs !== exp_v) begin
          fails++;
          $display("FAIL random cyc %0d: got %h expected %h", cyc, obs, exp_v);
        end
        advance();
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_ready_toggle();
    test_map_stall();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ofdm_frame_scheduler.md
OFDM_FRAME_SCHEDULER -- requirements
Module: ofdm_frame_scheduler

Interface
REQ-001 Parameter NSC, default 8: subcarriers (samples) per OFDM symbol.
REQ-002 Parameter W, default 32: sample width, {imag[15:0], real[15:0]}.
REQ-003 Parameter N_PRE, default 2: preamble symbols per frame.
REQ-004 Parameter N_DATA, default 4: data symbols per frame.
REQ-005 Parameter GAP_CYC, default 16: idle cycles after each frame.
REQ-006 Clocking/reset: one clock; reset is asynchronous and active-high; the clock port is aclk and the reset port is reset.
REQ-007 aclk  in  1  system clock.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 enable  in  1  level; frames are scheduled while high.
REQ-010 pre_tdata  in  W  preamble sample (requester 0).
REQ-011 pre_tvalid  in  1  preamble sample valid.
REQ-012 pre_tready  out  1  preamble sample accepted.
REQ-013 map_tdata  in  W  QAM mapper sample (requester 1).
REQ-014 map_tvalid  in  1  mapper sample valid.
REQ-015 map_tready  out  1  mapper sample accepted.
REQ-016 m_tdata  out  W  sample to IFFT.
REQ-017 m_tvalid  out  1  sample to IFFT valid.
REQ-018 m_tlast  out  1  last sample of symbol.
REQ-019 m_tready  in  1  IFFT ready.
REQ-020 frame_start  out  1  one-cycle pulse at first accepted preamble sample.
REQ-021 sym_idx  out  4  symbol index within frame, 0..N_PRE+N_DATA-1.
REQ-022 busy  out  1  high in PRE, DATA, GAP.

Function
REQ-023 FSM states IDLE, PRE, DATA, GAP; state, sample counter (0..NSC-1), symbol counter and gap counter are registered.
REQ-024 IDLE -> PRE when enable=1; otherwise stay IDLE.
REQ-025 PRE: m_tdata=pre_tdata, m_tvalid=pre_tvalid, pre_tready=m_tready, map_tready=0 (combinational, zero latency).
REQ-026 DATA: m_tdata=map_tdata, m_tvalid=map_tvalid, map_tready=m_tready, pre_tready=0.
REQ-027 IDLE/GAP: m_tvalid=0, m_tlast=0, m_tdata=0, pre_tready=0, map_tready=0.
REQ-028 A transfer occurs only when m_tvalid and m_tready are both 1; counters advance only on transfers.
REQ-029 m_tlast = m_tvalid when sample counter = NSC-1; sample counter wraps to 0 on that transfer.
REQ-030 On last-sample transfer, sym_idx increments; PRE -> DATA after N_PRE symbols; DATA -> GAP after N_DATA symbols.
REQ-031 GAP lasts exactly GAP_CYC cycles, then -> PRE if enable=1 else IDLE; sym_idx cleared to 0 on leaving GAP.
REQ-032 enable falling mid-frame does not truncate; the frame and gap complete.
REQ-033 Source stalls (tvalid=0) or sink stalls (m_tready=0) hold all counters; no sample dropped or duplicated.
REQ-034 frame_start = 1 only on the transfer with state=PRE, sym_idx=0, sample counter=0.
REQ-035 Source tlast is not an input; symbol boundaries are set solely by the sample counter.

Reset
REQ-036 reset asserted: state IDLE, all counters 0, sym_idx=0, busy=0, frame_start=0, all tvalid/tready outputs 0, immediately (asynchronous).
REQ-037 reset mid-frame abandons the frame; after release the next frame starts at PRE, sym_idx=0.

Structure
REQ-038 Shared package ofdm_pkg holds NSC, W, N_PRE, N_DATA, GAP_CYC defaults and the state encoding.
REQ-039 Single module; no sub-module; output mux and FSM in one block.

Verification
REQ-040 enable=1, both sources always valid, m_tready=1 -> 16 pre samples, 32 map samples, m_tlast on samples 8,16,...,48, then 16 idle cycles, next frame_start at cycle 65.
REQ-041 m_tready toggling 1/0 each cycle -> identical sample sequence to REQ-040, frame length 96 cycles, no lost/duplicated data.
REQ-042 map_tvalid=0 for 5 cycles at DATA sample 3 -> m_tvalid=0 those cycles, sample counter holds at 3, map_tready=m_tready throughout.
REQ-043 enable dropped during DATA symbol 1 -> frame finishes (sym_idx reaches 5), GAP 16 cycles, then IDLE, busy=0.
REQ-044 reset pulsed at PRE sample 5 -> outputs 0 same cycle; after release with enable=1 frame_start on first transfer, sym_idx=0.
REQ-045 In PRE, map_tvalid=1 continuously -> map_tready=0, no mapper sample consumed until DATA.
